// File: rtl/branch_issue_sched.sv
// branch_issue_sched: branch reservation station, oldest-ready-first issue (disp_* in, wb_* wakeup, flush, iss_* out, occupancy); `BRQ_WAKEUP_BYPASS_EN enables same-cycle wakeup issue
module branch_issue_sched #(
  parameter int NR_ENTRIES = 4,
  parameter int XLEN       = 64,
  parameter int ID_W       = 6,
  parameter int BQID_W     = 3,
  parameter int CTRL_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [ID_W-1:0]                 disp_id,
  input  logic [BQID_W-1:0]               disp_bqid,
  input  logic [XLEN-1:0]                 disp_pc,
  input  logic [XLEN-1:0]                 disp_imm,
  input  logic [CTRL_W-1:0]               disp_op,
  input  logic                            disp_rs1_rdy,
  input  logic                            disp_rs2_rdy,
  input  logic [ID_W-1:0]                 disp_rs1_tag,
  input  logic [ID_W-1:0]                 disp_rs2_tag,
  input  logic [XLEN-1:0]                 disp_rs1_val,
  input  logic [XLEN-1:0]                 disp_rs2_val,
  input  logic                            wb_valid,
  input  logic [ID_W-1:0]                 wb_tag,
  input  logic [XLEN-1:0]                 wb_val,
  input  logic                            flush,
  output logic                            iss_valid,
  input  logic                            iss_ready,
  output logic [ID_W-1:0]                 iss_id,
  output logic [BQID_W-1:0]               iss_bqid,
  output logic [XLEN-1:0]                 iss_pc,
  output logic [XLEN-1:0]                 iss_imm,
  output logic [CTRL_W-1:0]               iss_op,
  output logic [XLEN-1:0]                 iss_rs1val,
  output logic [XLEN-1:0]                 iss_rs2val,
  output logic [$clog2(NR_ENTRIES):0]     occupancy
);
  localparam int CW = $clog2(NR_ENTRIES) + 1;
  localparam int IW = $clog2(NR_ENTRIES);
  logic [NR_ENTRIES-1:0] vld, r1, r2, rdy, byp1, byp2, gnt;
  logic [NR_ENTRIES-1:0] older [NR_ENTRIES];
  logic [ID_W-1:0] id [NR_ENTRIES];
  logic [ID_W-1:0] t1 [NR_ENTRIES];
  logic [ID_W-1:0] t2 [NR_ENTRIES];
  logic [BQID_W-1:0] bq [NR_ENTRIES];
  logic [XLEN-1:0] pc [NR_ENTRIES];
  logic [XLEN-1:0] imm [NR_ENTRIES];
  logic [XLEN-1:0] v1 [NR_ENTRIES];
  logic [XLEN-1:0] v2 [NR_ENTRIES];
  logic [CTRL_W-1:0] op [NR_ENTRIES];
  logic [CW-1:0] cnt;
  logic [IW-1:0] fslot;
  logic do_disp, do_iss, d_w1, d_w2;
  assign occupancy = cnt;
  assign disp_ready = cnt < CW'(NR_ENTRIES);
  assign do_disp = disp_valid && disp_ready;
  assign do_iss = iss_valid && iss_ready;
  assign iss_valid = |gnt;
  assign d_w1 = !disp_rs1_rdy && wb_valid && disp_rs1_tag == wb_tag;
  assign d_w2 = !disp_rs2_rdy && wb_valid && disp_rs2_tag == wb_tag;
  always_comb begin
    fslot = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) fslot = vld[i] ? fslot : IW'(i);
    for (int i = 0; i < NR_ENTRIES; i++) begin
      byp1[i] = !r1[i] && wb_valid && t1[i] == wb_tag;
      byp2[i] = !r2[i] && wb_valid && t2[i] == wb_tag;
    end
`ifdef BRQ_WAKEUP_BYPASS_EN
    rdy = vld & (r1 | byp1) & (r2 | byp2);
`else
    rdy = vld & r1 & r2;
`endif
  end
  // older[j][i] set means entry j was dispatched before entry i
  always_comb begin
    logic [NR_ENTRIES-1:0] col;
    col = '0;
    gnt = '0;
    iss_id = '0;
    iss_bqid = '0;
    iss_pc = '0;
    iss_imm = '0;
    iss_op = '0;
    iss_rs1val = '0;
    iss_rs2val = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      for (int j = 0; j < NR_ENTRIES; j++) col[j] = (j != i) && older[j][i];
      gnt[i] = rdy[i] && !(|(rdy & col));
      iss_id |= {ID_W{gnt[i]}} & id[i];
      iss_bqid |= {BQID_W{gnt[i]}} & bq[i];
      iss_pc |= {XLEN{gnt[i]}} & pc[i];
      iss_imm |= {XLEN{gnt[i]}} & imm[i];
      iss_op |= {CTRL_W{gnt[i]}} & op[i];
`ifdef BRQ_WAKEUP_BYPASS_EN
      iss_rs1val |= {XLEN{gnt[i]}} & (r1[i] ? v1[i] : wb_val);
      iss_rs2val |= {XLEN{gnt[i]}} & (r2[i] ? v2[i] : wb_val);
`else
      iss_rs1val |= {XLEN{gnt[i]}} & v1[i];
      iss_rs2val |= {XLEN{gnt[i]}} & v2[i];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (byp1[i]) begin
          r1[i] <= 1'b1;
          v1[i] <= wb_val;
        end
        if (byp2[i]) begin
          r2[i] <= 1'b1;
          v2[i] <= wb_val;
        end
        if (do_iss && gnt[i]) vld[i] <= 1'b0;
      end
      if (do_disp) begin
        vld[fslot] <= 1'b1;
        id[fslot] <= disp_id;
        bq[fslot] <= disp_bqid;
        pc[fslot] <= disp_pc;
        imm[fslot] <= disp_imm;
        op[fslot] <= disp_op;
        t1[fslot] <= disp_rs1_tag;
        t2[fslot] <= disp_rs2_tag;
        r1[fslot] <= disp_rs1_rdy || d_w1;
        r2[fslot] <= disp_rs2_rdy || d_w2;
        v1[fslot] <= disp_rs1_rdy ? disp_rs1_val : wb_val;
        v2[fslot] <= disp_rs2_rdy ? disp_rs2_val : wb_val;
        older[fslot] <= '0;
        for (int j = 0; j < NR_ENTRIES; j++) if (IW'(j) != fslot) older[j][fslot] <= 1'b1;
      end
      cnt <= cnt + CW'(do_disp) - CW'(do_iss);
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) if (!rst && disp_valid && !disp_ready) $error("branch_issue_sched: dispatch while full");
`endif
endmodule

// File: tb/tb_branch_issue_sched.sv
// tb_branch_issue_sched: directed stimulus with issue scoreboard for branch_issue_sched
module tb_branch_issue_sched;
  logic clk = 0, rst = 1;
  logic disp_valid = 0, disp_ready;
  logic [5:0] disp_id = 0, disp_rs1_tag = 0, disp_rs2_tag = 0, wb_tag = 0, iss_id;
  logic [2:0] disp_bqid = 0, iss_bqid;
  logic [63:0] disp_pc = 0, disp_imm = 0, disp_rs1_val = 0, disp_rs2_val = 0, wb_val = 0;
  logic [3:0] disp_op = 0, iss_op;
  logic disp_rs1_rdy = 0, disp_rs2_rdy = 0, wb_valid = 0, flush = 0, iss_valid, iss_ready = 1;
  logic [63:0] iss_pc, iss_imm, iss_rs1val, iss_rs2val;
  logic [2:0] occupancy;
  int vec = 0, miss = 0;
  typedef struct {logic [5:0] id; logic [63:0] a, b;} exp_t;
  exp_t sbq[$];
  exp_t m_e;
  branch_issue_sched dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_id(disp_id),
    .disp_bqid(disp_bqid), .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_op(disp_op),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_tag(disp_rs2_tag), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .flush(flush), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_id(iss_id), .iss_bqid(iss_bqid), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_op(iss_op), .iss_rs1val(iss_rs1val), .iss_rs2val(iss_rs2val), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic disp(input logic [5:0] i, input logic ra, input logic [5:0] ta, input logic [63:0] a,
                      input logic rb, input logic [5:0] tb, input logic [63:0] b);
    disp_valid = 1;
    disp_id = i;
    disp_bqid = i[2:0];
    disp_pc = {56'd0, i, 2'b00};
    disp_imm = {58'd0, i};
    disp_op = i[3:0];
    disp_rs1_rdy = ra;
    disp_rs1_tag = ta;
    disp_rs1_val = a;
    disp_rs2_rdy = rb;
    disp_rs2_tag = tb;
    disp_rs2_val = b;
  endtask
  task automatic push(input logic [5:0] i, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.id = i;
    e.a = a;
    e.b = b;
    sbq.push_back(e);
  endtask
  always @(negedge clk) if (!rst && iss_valid && iss_ready) begin
    if (sbq.size() == 0) begin
      vec++;
      miss++;
      $error("FAIL spurious_issue: observed id %0d expected no issue", iss_id);
    end else begin
      m_e = sbq.pop_front();
      chk("iss_id", 64'(iss_id), 64'(m_e.id));
      chk("iss_rs1val", iss_rs1val, m_e.a);
      chk("iss_rs2val", iss_rs2val, m_e.b);
      chk("iss_pc", iss_pc, {56'd0, m_e.id, 2'b00});
      chk("iss_imm", iss_imm, {58'd0, m_e.id});
      chk("iss_bqid", 64'(iss_bqid), 64'(m_e.id[2:0]));
      chk("iss_op", 64'(iss_op), 64'(m_e.id[3:0]));
    end
  end
  initial begin
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_disp_ready", 64'(disp_ready), 1);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_iss_pc", iss_pc, 0);
    chk("rst_iss_id", 64'(iss_id), 0);
    // single ready branch: issue one cycle after dispatch
    tick();
    disp(5, 1, 0, 10, 1, 0, 10);
    push(5, 10, 10);
    @(negedge clk);
    chk("t1_lat_iss_valid", 64'(iss_valid), 0);
    tick();
    disp_valid = 0;
    @(negedge clk);
    chk("t1_iss_valid", 64'(iss_valid), 1);
    chk("t1_occ", 64'(occupancy), 1);
    tick();
    @(negedge clk);
    chk("t1_occ_after", 64'(occupancy), 0);
    chk("t1_idle", 64'(iss_valid), 0);
    // younger ready entry bypasses older waiting one
    tick();
    disp(1, 0, 9, 0, 1, 0, 3);
    tick();
    disp(2, 1, 0, 7, 1, 0, 8);
    push(2, 7, 8);
    push(1, 64'h40, 3);
    @(negedge clk);
    chk("t2_none_ready", 64'(iss_valid), 0);
    tick();
    disp_valid = 0;
    @(negedge clk);
    chk("t2_first_id", 64'(iss_id), 2);
    tick();
    wb_valid = 1;
    wb_tag = 9;
    wb_val = 64'h40;
    @(negedge clk);
`ifdef BRQ_WAKEUP_BYPASS_EN
    chk("t2_bypass_valid", 64'(iss_valid), 1);
`else
    chk("t2_wake_lat_valid", 64'(iss_valid), 0);
`endif
    tick();
    wb_valid = 0;
`ifndef BRQ_WAKEUP_BYPASS_EN
    @(negedge clk);
    chk("t2_wake_id", 64'(iss_id), 1);
`endif
    tick();
    @(negedge clk);
    chk("t2_occ", 64'(occupancy), 0);
    // fill the station, all waiting on tag 7
    for (int i = 0; i < 4; i++) begin
      tick();
      disp(6'(11 + i), 0, 7, 0, 1, 0, 64'(i));
      push(6'(11 + i), 64'h77, 64'(i));
    end
    tick();
    disp_valid = 0;
    @(negedge clk);
    chk("t3_full_ready", 64'(disp_ready), 0);
    chk("t3_full_occ", 64'(occupancy), 4);
    chk("t3_full_idle", 64'(iss_valid), 0);
    tick();
    wb_valid = 1;
    wb_tag = 7;
    wb_val = 64'h77;
    tick();
    wb_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    chk("t3_drained", 64'(occupancy), 0);
    // back-pressure holds the selected entry
    iss_ready = 0;
    tick();
    disp(20, 1, 0, 1, 1, 0, 2);
    push(20, 1, 2);
    tick();
    disp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(iss_valid), 1);
      chk("t4_hold_id", 64'(iss_id), 20);
      chk("t4_hold_occ", 64'(occupancy), 1);
      tick();
    end
    iss_ready = 1;
    tick();
    @(negedge clk);
    chk("t4_freed", 64'(occupancy), 0);
    // older entry waking up overtakes a stalled selection
    iss_ready = 0;
    tick();
    disp(30, 0, 15, 0, 1, 0, 1);
    tick();
    disp(31, 1, 0, 2, 1, 0, 3);
    tick();
    disp(32, 0, 15, 0, 1, 0, 4);
    push(30, 64'h55, 1);
    push(31, 2, 3);
    push(32, 64'h55, 4);
    tick();
    disp_valid = 0;
    @(negedge clk);
    chk("t5_stall_id", 64'(iss_id), 31);
    tick();
    wb_valid = 1;
    wb_tag = 15;
    wb_val = 64'h55;
`ifdef BRQ_WAKEUP_BYPASS_EN
    @(negedge clk);
    chk("t5_bypass_oldest", 64'(iss_id), 30);
`endif
    tick();
    wb_valid = 0;
    @(negedge clk);
    chk("t5_oldest_id", 64'(iss_id), 30);
    iss_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    chk("t5_drained", 64'(occupancy), 0);
    // flush beats concurrent dispatch and wakeup
    for (int i = 0; i < 3; i++) begin
      tick();
      disp(6'(40 + i), 0, 5, 0, 1, 0, 0);
    end
    tick();
    iss_ready = 0;
    flush = 1;
    disp(43, 1, 0, 1, 1, 0, 1);
    wb_valid = 1;
    wb_tag = 5;
    wb_val = 64'h1;
    @(negedge clk);
    chk("t6_pre_occ", 64'(occupancy), 3);
    tick();
    flush = 0;
    disp_valid = 0;
    wb_valid = 0;
    iss_ready = 1;
    @(negedge clk);
    chk("t6_occ", 64'(occupancy), 0);
    chk("t6_disp_ready", 64'(disp_ready), 1);
    chk("t6_idle", 64'(iss_valid), 0);
    tick();
    @(negedge clk);
    chk("t6_idle2", 64'(iss_valid), 0);
    // dispatch catches a same-cycle writeback
    tick();
    disp(50, 1, 0, 4, 0, 12, 0);
    wb_valid = 1;
    wb_tag = 12;
    wb_val = 64'h99;
    push(50, 4, 64'h99);
    @(negedge clk);
    chk("t7_lat_valid", 64'(iss_valid), 0);
    tick();
    disp_valid = 0;
    wb_valid = 0;
    @(negedge clk);
    chk("t7_valid", 64'(iss_valid), 1);
    chk("t7_rs2", iss_rs2val, 64'h99);
    tick();
    @(negedge clk);
    chk("t7_occ", 64'(occupancy), 0);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
